rr_mux_arb: RTL

RR_MUX_ARB -- requirements
Module: rr_mux_arb

---
 rtl/rr_mux_pkg.sv | 12 +
 rtl/rr_mux_arb_if.sv | 30 +++
 rtl/rr_mux_arb_pick.sv | 32 +++
 rtl/rr_mux_arb.sv | 99 +++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// Shared constants and helpers for the round-robin / manual-select mux arbiter.
package rr_mux_pkg;

   localparam logic MODE_SEL = 1'b0;
   localparam logic MODE_RR  = 1'b1;

   // Select/channel-id width for a given channel count; never narrower than one bit.
   function automatic int sel_width(input int n_ch);
      return (n_ch > 1) ? $clog2(n_ch) : 1;
   endfunction

endpackage

// File: rtl/rr_mux_arb_if.sv
// Handshake bundle between N_CH upstream producers, the arbiter, and one downstream consumer.
interface rr_mux_arb_if #(
   parameter int N_CH = 8,
   parameter int DW   = 8,
   parameter int SW   = $clog2(N_CH)
);

   logic [N_CH*DW-1:0] in_data;
   logic [N_CH-1:0]    in_valid;
   logic [N_CH-1:0]    in_ready;
   logic               mode;
   logic [SW-1:0]      sel;
   logic [DW-1:0]      out_data;
   logic               out_valid;
   logic               out_ready;
   logic [SW-1:0]      out_ch;

   // Producer/consumer side (testbench or surrounding fabric).
   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_valid, out_ch
   );

   // Arbiter side.
   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_valid, out_ch
   );

endinterface

// File: rtl/rr_mux_arb_pick.sv
// Rotating-priority search: first requester strictly after ptr, wrapping at N_CH.
// Purely combinational; no backpressure of its own.
module rr_pick #(
   parameter int N_CH = 8,
   parameter int SW   = $clog2(N_CH)
) (
   input  logic [N_CH-1:0] req,
   input  logic [SW-1:0]   ptr,
   output logic            gnt_vld,
   output logic [SW-1:0]   gnt_idx
);

   int w_best;
   int w_dist;

   // Distance from ptr+1 going upward with wrap; the smallest distance wins.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      w_best  = N_CH;
      w_dist  = 0;
      for (int i = 0; i < N_CH; i++) begin
         w_dist = (i + N_CH - int'(ptr) - 1) % N_CH;
         if (req[i] && (w_dist < w_best)) begin
            w_best  = w_dist;
            gnt_vld = 1'b1;
            gnt_idx = SW'(i);
         end
      end
   end

endmodule

// File: rtl/rr_mux_arb.sv
// N_CH:1 mux with manual or round-robin grant into a single output register; 1-cycle latency.
// A held, unaccepted output beat blocks every input; drain and refill happen in the same cycle.
module rr_mux_arb
   import rr_mux_pkg::*;
#(
   parameter int N_CH = 8,
   parameter int DW   = 8,
   parameter int SW   = $clog2(N_CH)
) (
   input  logic             clk,
   input  logic             rst_n,
   rr_mux_arb_if.slave      bus
);

   logic [SW-1:0]   r_ptr;
   logic            r_out_valid;
   logic [DW-1:0]   r_out_data;
   logic [SW-1:0]   r_out_ch;

   logic            w_load_en;
   logic            w_pick_vld;
   logic [SW-1:0]   w_pick_idx;
   logic            w_gnt_vld;
   logic [SW-1:0]   w_gnt_idx;
   logic [N_CH-1:0] w_gnt;
   logic [DW-1:0]   w_sel_data;

   rr_pick #(
      .N_CH (N_CH),
      .SW   (SW)
   ) u_pick (
      .req     (bus.in_valid),
      .ptr     (r_ptr),
      .gnt_vld (w_pick_vld),
      .gnt_idx (w_pick_idx)
   );

   assign w_load_en = !r_out_valid || bus.out_ready;

   // Manual mode grants only an in-range, valid sel; an out-of-range sel matches no channel.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      if (bus.mode == MODE_RR) begin
         w_gnt_vld = w_pick_vld;
         w_gnt_idx = w_pick_idx;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if ((bus.sel == SW'(i)) && bus.in_valid[i]) begin
               w_gnt_vld = 1'b1;
               w_gnt_idx = SW'(i);
            end
         end
      end
   end

   always_comb begin
      w_gnt      = '0;
      w_sel_data = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (w_gnt_vld && (w_gnt_idx == SW'(i))) begin
            w_gnt[i]   = 1'b1;
            w_sel_data = bus.in_data[i*DW +: DW];
         end
      end
   end

   assign bus.in_ready = w_gnt & {N_CH{w_load_en && rst_n}};

   // ptr starts at N_CH-1 so channel 0 is first in line after reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_ch    <= '0;
         r_ptr       <= SW'(N_CH - 1);
      end else if (w_load_en) begin
         r_out_valid <= w_gnt_vld;
         if (w_gnt_vld) begin
            r_out_data <= w_sel_data;
            r_out_ch   <= w_gnt_idx;
            if (bus.mode == MODE_RR) begin
               r_ptr <= w_gnt_idx;
            end
         end
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_ch    = r_out_ch;

   a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(bus.in_ready));

   a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (r_out_valid && !bus.out_ready) |=> ($stable(r_out_data) && $stable(r_out_ch) && r_out_valid));

endmodule
